// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the MIPS pipeline registers.
//   XLEN          : datapath width of instruction and PC
//   NOP_INSTR     : instruction injected on bubble/flush (sll $0,$0,0)
//   SKID_EMPTY/FULL : skid-buffer state encoding
//   pipe_entry_t  : one pipeline entry {instr, pc_add_4, valid, adel}
// -----------------------------------------------------------------------------
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [0:0] SKID_EMPTY = 1'b0;
    localparam logic [0:0] SKID_FULL  = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_add_4;
        logic            valid;
        logic            adel;
    } pipe_entry_t;

    // PC+4 keeps the alignment of the PC itself, so low bits reveal misalignment.
    function automatic logic is_misaligned(input logic [XLEN-1:0] pc_add_4);
        return pc_add_4[1:0] != 2'b00;
    endfunction
endpackage

// File: rtl/if_id_stage_reg_if.sv
// -----------------------------------------------------------------------------
// if_id_stage_reg_if
// Bundle of fetch-side inputs, decode controls and decode-side outputs of the
// IF/ID boundary.
//   master : fetch/hazard side (drives F inputs, StallD, FlushD)
//   slave  : the IF/ID stage register
// Optional StallCnt/FlushCnt exist only when IFID_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
interface if_id_stage_reg_if #(parameter int WIDTH = 32) ();
    logic [WIDTH-1:0] InstrF;
    logic [WIDTH-1:0] PC_add_4F;
    logic             ValidF;
    logic             StallD;
    logic             FlushD;
    logic [WIDTH-1:0] InstrD;
    logic [WIDTH-1:0] PC_add_4D;
    logic             ValidD;
    logic             AdEL_D;
    logic             SkidFull;
`ifdef IFID_PERF_CNT_EN
    logic [31:0]      StallCnt;
    logic [31:0]      FlushCnt;
`endif

    modport master (
        output InstrF, PC_add_4F, ValidF, StallD, FlushD,
        input  InstrD, PC_add_4D, ValidD, AdEL_D, SkidFull
`ifdef IFID_PERF_CNT_EN
        , input StallCnt, FlushCnt
`endif
    );

    modport slave (
        input  InstrF, PC_add_4F, ValidF, StallD, FlushD,
        output InstrD, PC_add_4D, ValidD, AdEL_D, SkidFull
`ifdef IFID_PERF_CNT_EN
        , output StallCnt, FlushCnt
`endif
    );
endinterface

// File: rtl/if_id_skid.sv
// -----------------------------------------------------------------------------
// if_id_skid
// One-entry skid buffer with its EMPTY/FULL FSM. Catches a fetch that lands
// while decode is stalled so it can be handed to decode on release.
//   clk, rst   : clock, async active-low reset
//   i_stall    : StallD
//   i_flush    : FlushD (clears the buffer, priority over stall)
//   i_valid_f  : ValidF
//   i_entry    : pre-formatted F-side entry
//   o_full     : buffer holds an entry
//   o_entry    : buffered entry
// -----------------------------------------------------------------------------
module if_id_skid
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_valid_f,
    input  pipe_entry_t i_entry,
    output logic        o_full,
    output pipe_entry_t o_entry
);
    logic [0:0]  r_state;
    pipe_entry_t r_entry;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SKID_EMPTY;
            r_entry <= '0;
        end else if (i_flush) begin
            r_state <= SKID_EMPTY;
            r_entry <= '0;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (i_stall && i_valid_f) begin
                        r_state <= SKID_FULL;
                        r_entry <= i_entry;
                    end
                end
                SKID_FULL: begin
                    // While stalled, fetch is held off and its inputs ignored.
                    if (!i_stall) r_state <= SKID_EMPTY;
                end
                default: r_state <= SKID_EMPTY;
            endcase
        end
    end

    assign o_full  = (r_state == SKID_FULL);
    assign o_entry = r_entry;
endmodule

// File: rtl/if_id_stage_reg.sv
// -----------------------------------------------------------------------------
// if_id_stage_reg
// IF/ID pipeline register of the 5-stage MIPS core: holds under StallD,
// bubbles on FlushD, skids one fetch arriving during a stall, and flags
// misaligned fetch addresses (AdEL) for the exception unit.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : if_id_stage_reg_if.slave (F inputs, StallD/FlushD, D outputs,
//          SkidFull; StallCnt/FlushCnt when IFID_PERF_CNT_EN is defined)
// Optional feature macro: IFID_PERF_CNT_EN (stall/flush event counters).
// -----------------------------------------------------------------------------
module if_id_stage_reg
    import cpu_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    if_id_stage_reg_if.slave  bus
);
    logic        w_misalign;
    pipe_entry_t w_f_entry;
    logic        w_skid_full;
    pipe_entry_t w_skid_entry;
    pipe_entry_t r_d;

    // Only a real fetch can raise an address error.
    assign w_misalign = bus.ValidF && is_misaligned(bus.PC_add_4F);

    // F-side entry: bubbles and faulting fetches carry a NOP; a faulting
    // fetch stays valid so the exception retires with its PC.
    always_comb begin
        w_f_entry.instr    = (bus.ValidF && !w_misalign) ? bus.InstrF : NOP_INSTR;
        w_f_entry.pc_add_4 = bus.PC_add_4F;
        w_f_entry.valid    = bus.ValidF;
        w_f_entry.adel     = w_misalign;
    end

    if_id_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_stall   (bus.StallD),
        .i_flush   (bus.FlushD),
        .i_valid_f (bus.ValidF),
        .i_entry   (w_f_entry),
        .o_full    (w_skid_full),
        .o_entry   (w_skid_entry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d <= '{instr: NOP_INSTR, pc_add_4: '0, valid: 1'b0, adel: 1'b0};
        end else if (bus.FlushD) begin
            // PC still loads so EPC bookkeeping sees the redirect point.
            r_d <= '{instr: NOP_INSTR, pc_add_4: bus.PC_add_4F, valid: 1'b0, adel: 1'b0};
        end else if (!bus.StallD) begin
            // A pending skid entry is older than whatever fetch shows now;
            // fetch re-presents its current word since it was stalled.
            r_d <= w_skid_full ? w_skid_entry : w_f_entry;
        end
    end

    assign bus.InstrD    = r_d.instr;
    assign bus.PC_add_4D = r_d.pc_add_4;
    assign bus.ValidD    = r_d.valid;
    assign bus.AdEL_D    = r_d.adel;
    assign bus.SkidFull  = w_skid_full;

`ifdef IFID_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bus.StallD && !bus.FlushD) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (bus.FlushD)                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign bus.StallCnt = r_stall_cnt;
    assign bus.FlushCnt = r_flush_cnt;
`endif
endmodule

// File: tb/tb_if_id_stage_reg.sv
module tb_if_id_stage_reg;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    if_id_stage_reg_if #(.WIDTH(32)) bus ();

    if_id_stage_reg #(.WIDTH(32), .NOP_INSTR(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state: decode contents and the skid as a queue.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        adel;
    } ent_t;
    ent_t        m_d;
    ent_t        m_q[$];
    logic [31:0] m_sc, m_fc;

    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic v, input logic s, input logic f);
        bus.InstrF = i; bus.PC_add_4F = p; bus.ValidF = v;
        bus.StallD = s; bus.FlushD = f;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        n_chk++; if (bus.InstrD !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", bus.InstrD); end
        n_chk++; if (bus.PC_add_4D !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", bus.PC_add_4D); end
        n_chk++; if (bus.ValidD !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.ValidD); end
        n_chk++; if (bus.AdEL_D !== 1'b0) begin n_fail++; $display("FAIL reset_adel got %b exp 0", bus.AdEL_D); end
        n_chk++; if (bus.SkidFull !== 1'b0) begin n_fail++; $display("FAIL reset_skid got %b exp 0", bus.SkidFull); end
        @(negedge clk); rst = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        drive(32'h20080005, 32'h4, 1'b1, 1'b0, 1'b0);
        tick();
        n_chk++; if (bus.InstrD !== 32'h20080005 || bus.PC_add_4D !== 32'h4 || bus.ValidD !== 1'b1)
            begin n_fail++; $display("FAIL stream0 got %h/%h/%b exp 20080005/4/1", bus.InstrD, bus.PC_add_4D, bus.ValidD); end
        drive(32'h20090007, 32'h8, 1'b1, 1'b0, 1'b0);
        tick();
        n_chk++; if (bus.InstrD !== 32'h20090007 || bus.PC_add_4D !== 32'h8 || bus.ValidD !== 1'b1)
            begin n_fail++; $display("FAIL stream1 got %h/%h/%b exp 20090007/8/1", bus.InstrD, bus.PC_add_4D, bus.ValidD); end
    endtask

    task automatic test_stall_skid();
        drive(32'h01095020, 32'hC, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++; if (bus.InstrD !== 32'h20090007 || bus.PC_add_4D !== 32'h8)
                begin n_fail++; $display("FAIL stall_hold%0d got %h/%h exp 20090007/8", c, bus.InstrD, bus.PC_add_4D); end
            n_chk++; if (bus.SkidFull !== 1'b1)
                begin n_fail++; $display("FAIL stall_skidfull%0d got %b exp 1", c, bus.SkidFull); end
            drive(32'hBAD0BAD0, 32'h10, 1'b1, 1'b1, 1'b0);
        end
        drive(32'hAAAA0000, 32'h10, 1'b1, 1'b0, 1'b0);
        tick();
        n_chk++; if (bus.InstrD !== 32'h01095020 || bus.PC_add_4D !== 32'hC || bus.SkidFull !== 1'b0)
            begin n_fail++; $display("FAIL stall_release got %h/%h/%b exp 01095020/c/0", bus.InstrD, bus.PC_add_4D, bus.SkidFull); end
    endtask

    task automatic test_flush_over_stall();
        drive(32'h12345678, 32'h20, 1'b1, 1'b1, 1'b0);
        tick();
        n_chk++; if (bus.SkidFull !== 1'b1) begin n_fail++; $display("FAIL flush_prefill got %b exp 1", bus.SkidFull); end
        drive(32'h87654321, 32'h40, 1'b1, 1'b1, 1'b1);
        tick();
        n_chk++; if (bus.InstrD !== 32'h0 || bus.ValidD !== 1'b0 || bus.SkidFull !== 1'b0 || bus.PC_add_4D !== 32'h40)
            begin n_fail++; $display("FAIL flush got %h/%b/%b/%h exp 0/0/0/40", bus.InstrD, bus.ValidD, bus.SkidFull, bus.PC_add_4D); end
    endtask

    task automatic test_misaligned();
        drive(32'hDEADBEEF, 32'h16, 1'b1, 1'b0, 1'b0);
        tick();
        n_chk++; if (bus.AdEL_D !== 1'b1 || bus.InstrD !== 32'h0 || bus.ValidD !== 1'b1 || bus.PC_add_4D !== 32'h16)
            begin n_fail++; $display("FAIL misalign got %b/%h/%b/%h exp 1/0/1/16", bus.AdEL_D, bus.InstrD, bus.ValidD, bus.PC_add_4D); end
        drive(32'h11112222, 32'h1C, 1'b1, 1'b0, 1'b0);
        tick();
        n_chk++; if (bus.AdEL_D !== 1'b0 || bus.InstrD !== 32'h11112222)
            begin n_fail++; $display("FAIL misalign_clear got %b/%h exp 0/11112222", bus.AdEL_D, bus.InstrD); end
    endtask

    task automatic test_reset_midrun();
        drive(32'hCAFE0001, 32'h30, 1'b1, 1'b1, 1'b0);
        tick();
        n_chk++; if (bus.SkidFull !== 1'b1) begin n_fail++; $display("FAIL rstmid_prefill got %b exp 1", bus.SkidFull); end
        #2 rst = 1'b0;
        #1;
        n_chk++; if (bus.InstrD !== 32'h0 || bus.PC_add_4D !== 32'h0 || bus.ValidD !== 1'b0 || bus.AdEL_D !== 1'b0 || bus.SkidFull !== 1'b0)
            begin n_fail++; $display("FAIL rstmid got %h/%h/%b/%b/%b exp 0/0/0/0/0", bus.InstrD, bus.PC_add_4D, bus.ValidD, bus.AdEL_D, bus.SkidFull); end
        drive(32'h2010ABCD, 32'h4, 1'b1, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b1;
        tick();
        n_chk++; if (bus.InstrD !== 32'h2010ABCD || bus.ValidD !== 1'b1 || bus.PC_add_4D !== 32'h4)
            begin n_fail++; $display("FAIL rstmid_first got %h/%b/%h exp 2010abcd/1/4", bus.InstrD, bus.ValidD, bus.PC_add_4D); end
    endtask

    task automatic test_random();
        logic [31:0] ri, rp;
        logic        rv, rs, rf, mis;
        ent_t        fe;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0; #1;
        m_d = '{32'h0, 32'h0, 1'b0, 1'b0};
        m_q.delete();
        m_sc = 0; m_fc = 0;
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 400; c++) begin
            ri = $urandom;
            rv = ($urandom_range(0, 3) != 0);
            rp = $urandom & 32'hFFFF_FFFC;
            if (rv && $urandom_range(0, 7) == 0) rp[1:0] = 2'($urandom_range(1, 3));
            rs = ($urandom_range(0, 9) < 4);
            rf = ($urandom_range(0, 9) == 0);
            drive(ri, rp, rv, rs, rf);
            @(posedge clk);
            // Model: what decode should see after this edge.
            mis = rv && (rp % 4 != 0);
            fe  = '{(rv && !mis) ? ri : 32'h0, rp, rv, mis};
            if (rs && !rf) m_sc++;
            if (rf) m_fc++;
            if (rf) begin
                m_d = '{32'h0, rp, 1'b0, 1'b0};
                m_q.delete();
            end else if (!rs) begin
                if (m_q.size() > 0) m_d = m_q.pop_front();
                else                m_d = fe;
            end else if (m_q.size() == 0 && rv) begin
                m_q.push_back(fe);
            end
            #1;
            n_chk++;
            if (bus.InstrD !== m_d.instr || bus.PC_add_4D !== m_d.pc || bus.ValidD !== m_d.valid ||
                bus.AdEL_D !== m_d.adel || bus.SkidFull !== (m_q.size() != 0)) begin
                n_fail++;
                $display("FAIL random cyc%0d got %h/%h/%b/%b/%b exp %h/%h/%b/%b/%b", c,
                         bus.InstrD, bus.PC_add_4D, bus.ValidD, bus.AdEL_D, bus.SkidFull,
                         m_d.instr, m_d.pc, m_d.valid, m_d.adel, (m_q.size() != 0));
            end
`ifdef IFID_PERF_CNT_EN
            n_chk++;
            if (bus.StallCnt !== m_sc || bus.FlushCnt !== m_fc) begin
                n_fail++;
                $display("FAIL random_cnt cyc%0d got %0d/%0d exp %0d/%0d", c, bus.StallCnt, bus.FlushCnt, m_sc, m_fc);
            end
`endif
        end
    endtask

`ifdef IFID_PERF_CNT_EN
    task automatic test_perf();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0; #1;
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive(32'h0, 32'h4, 1'b0, 1'b1, (c == 2));
            tick();
        end
        drive(32'h0, 32'h4, 1'b0, 1'b0, 1'b1);
        tick();
        drive(32'h0, 32'h4, 1'b0, 1'b0, 1'b0);
        tick();
        n_chk++; if (bus.StallCnt !== 32'd4) begin n_fail++; $display("FAIL perf_stall got %0d exp 4", bus.StallCnt); end
        n_chk++; if (bus.FlushCnt !== 32'd2) begin n_fail++; $display("FAIL perf_flush got %0d exp 2", bus.FlushCnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush_over_stall();
        test_misaligned();
        test_reset_midrun();
        test_random();
`ifdef IFID_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/if_id_stage_reg.md
Name: if_id_stage_reg

Overview:
- Pipeline boundary between instruction fetch and decode in the 5-stage MIPS core.
- Captures the instruction word and PC+4 produced by fetch, and holds them under decode stall.
- Inserts a NOP bubble on flush.
- Contains a one-entry skid buffer so that a fetch landing during a decode stall is not lost.
- Flags misaligned fetch addresses for the exception unit (EPC path).

Parameters:
- WIDTH, 32, datapath width of the instruction and PC.
- NOP_INSTR, 32'h00000000, instruction word injected on bubble/flush (MIPS sll $0,$0,0).

Ports:
- clk  in  1  single system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- InstrF  in  WIDTH  instruction word from instruction memory, aligned with PC_add_4F.
- PC_add_4F  in  WIDTH  PC+4 of the fetched instruction.
- ValidF  in  1  fetch produced a real instruction this cycle.
- StallD  in  1  decode stall from hazard unit.
- FlushD  in  1  kill decode contents (branch/jump/exception redirect).
- InstrD  out  WIDTH  instruction to decode.
- PC_add_4D  out  WIDTH  PC+4 to decode.
- ValidD  out  1  InstrD is a real instruction.
- AdEL_D  out  1  fetch address was misaligned.
- SkidFull  out  1  skid holds an entry; the hazard unit must keep StallF high while this is 1 and StallD is 1.

Behaviour:
- Reset (rst=0, asynchronous): InstrD=NOP_INSTR, PC_add_4D=0, ValidD=0, AdEL_D=0, skid cleared, SkidFull=0.
- Latency: 1 cycle from F inputs to D outputs when not stalled and the skid is empty.
- Skid FSM, two states:
  - EMPTY:
    - StallD=1 & ValidF=1 & FlushD=0 -> capture {InstrF, PC_add_4F, misalign} into skid; go to FULL.
    - StallD=0 -> D regs load F inputs directly.
  - FULL:
    - StallD=1 -> D regs and skid both hold; new F inputs are ignored (fetch must be stalled).
    - StallD=0 -> D regs load from skid; go to EMPTY. The F inputs that cycle are discarded; fetch re-presents them because it was stalled.
- Stall with the skid EMPTY and ValidF=0: D regs hold; the skid stays EMPTY.
- FlushD (priority over StallD): next edge InstrD=NOP_INSTR, ValidD=0, AdEL_D=0; skid cleared to EMPTY. PC_add_4D loads PC_add_4F for EPC bookkeeping.
- Bubble: if ValidF=0 and the D regs load from F, then InstrD=NOP_INSTR and ValidD=0.
- Misalignment check: computed on the F side as (PC_add_4F[1:0] != 2'b00).
  - If set: AdEL_D=1, InstrD=NOP_INSTR, ValidD=1 (so the exception retires with its PC), PC_add_4D loads normally.
- Arithmetic: no wrap logic; PC_add_4 is passed through unmodified.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- Defined: adds outputs StallCnt[31:0] and FlushCnt[31:0].
  - StallCnt increments every cycle StallD=1 & FlushD=0.
  - FlushCnt increments every cycle FlushD=1.
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - NOP_INSTR constant.
  - Skid state encoding (SKID_EMPTY=1'b0, SKID_FULL=1'b1).
  - Pipeline-entry struct {instr, pc_add_4, valid, adel}.
- One natural sub-module: if_id_skid (one-entry buffer plus FSM). It is instantiated once; the D registers live in the parent.

Test Plan:
- Reset: drive rst=0 mid-run with the skid FULL -> all outputs take their reset values immediately; SkidFull=0. After release, the first ValidF instruction appears on InstrD one cycle later.
- Streaming: feed InstrF=32'h20080005, 32'h20090007, PC_add_4F=4 then 8, no stall -> InstrD matches each word one cycle later; PC_add_4D=4 then 8; ValidD=1.
- Stall with skid:
  - StallD=1 for 3 cycles while InstrF=32'h01095020 (PC_add_4F=C) arrives on the first stall cycle -> InstrD holds its prior value; SkidFull=1 for the remaining stall cycles.
  - On release, InstrD=32'h01095020, PC_add_4D=C, SkidFull=0.
- Flush over stall: StallD=1 & FlushD=1 with the skid FULL -> next edge InstrD=0, ValidD=0, SkidFull=0.
- Misaligned fetch: PC_add_4F=32'h00000016 -> AdEL_D=1, InstrD=0, ValidD=1, PC_add_4D=32'h16.
- Perf counters (IFID_PERF_CNT_EN defined): 5 stall cycles and 2 flush cycles, one of them overlapping a stall -> StallCnt=4, FlushCnt=2.
